// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared pipeline types for the forwarding/hazard unit: forward-select
// encodings, stall FSM states and the shadow stage record.
package forwarding_hazard_unit_pkg;

  // Widest register index the stage record can carry; narrower indices are zero-extended.
  localparam int unsigned RD_MAX_W = 8;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } stall_state_e;

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                reg_write;
    logic                mem_read;
  } stage_rec_t;

  localparam stage_rec_t STAGE_BUBBLE = '0;

  function automatic logic rec_produces(input stage_rec_t rec, input logic [RD_MAX_W-1:0] src);
    return rec.valid && rec.reg_write && (rec.rd == src);
  endfunction

endpackage

// File: rtl/forwarding_hazard_unit_fwd_compare.sv
// Single-operand forward select: the newest in-flight producer of the source wins.
module fwd_compare
  import forwarding_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_W = 3
) (
  input  logic [REG_W-1:0] i_src,
  input  logic             i_used,
  input  logic             i_valid,
  input  stage_rec_t       i_ex,
  input  stage_rec_t       i_mem,
  output fwd_sel_e         o_sel
);

  logic [RD_MAX_W-1:0] w_src;

  always_comb begin
    w_src = RD_MAX_W'(i_src);
    o_sel = FWD_RF;
    if (i_used && i_valid) begin
      if (rec_produces(i_ex, w_src)) begin
        o_sel = FWD_EXMEM;
      end else if (rec_produces(i_mem, w_src)) begin
        o_sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Forwarding and load-use hazard unit: tracks EX/MEM shadow records, registers
// operand forward selects one cycle ahead of execute, and inserts single-cycle stalls.
module forwarding_hazard_unit
  import forwarding_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_src1_used,
  input  logic             id_src2_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_valid,
  input  logic             flush,
  output logic [1:0]       Forward1Sel,
  output logic [1:0]       Forward2Sel,
  output logic             stall,
  output logic [15:0]      stall_count
);

  stage_rec_t   r_ex;
  stage_rec_t   r_mem;
  stall_state_e r_state;
  fwd_sel_e     r_fwd1;
  fwd_sel_e     r_fwd2;
  logic [15:0]  r_stall_cnt;

  stage_rec_t   w_id_rec;
  fwd_sel_e     w_sel1;
  fwd_sel_e     w_sel2;
  logic         w_hazard;
  logic         w_stall;

  fwd_compare #(.REG_W(REG_W)) u_fwd1 (
    .i_src   (id_src1),
    .i_used  (id_src1_used),
    .i_valid (id_valid),
    .i_ex    (r_ex),
    .i_mem   (r_mem),
    .o_sel   (w_sel1)
  );

  fwd_compare #(.REG_W(REG_W)) u_fwd2 (
    .i_src   (id_src2),
    .i_used  (id_src2_used),
    .i_valid (id_valid),
    .i_ex    (r_ex),
    .i_mem   (r_mem),
    .o_sel   (w_sel2)
  );

  always_comb begin
    w_id_rec           = STAGE_BUBBLE;
    w_id_rec.valid     = id_valid;
    w_id_rec.rd        = RD_MAX_W'(id_rd);
    w_id_rec.reg_write = id_reg_write;
    w_id_rec.mem_read  = id_mem_read;

    w_hazard = id_valid && r_ex.valid && r_ex.mem_read &&
               ((id_src1_used && (RD_MAX_W'(id_src1) == r_ex.rd)) ||
                (id_src2_used && (RD_MAX_W'(id_src2) == r_ex.rd)));
    // Flush squashes the dependent instruction, so it wins over the hazard.
    w_stall  = w_hazard && (r_state == ST_RUN) && !flush;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ex        <= STAGE_BUBBLE;
      r_mem       <= STAGE_BUBBLE;
      r_state     <= ST_RUN;
      r_fwd1      <= FWD_RF;
      r_fwd2      <= FWD_RF;
      r_stall_cnt <= '0;
    end else begin
      r_mem <= r_ex;
      if (flush || w_stall) begin
        r_ex   <= STAGE_BUBBLE;
        r_fwd1 <= FWD_RF;
        r_fwd2 <= FWD_RF;
      end else begin
        r_ex   <= w_id_rec;
        r_fwd1 <= w_sel1;
        r_fwd2 <= w_sel2;
      end
      if (w_stall) begin
        r_state <= ST_STALL;
      end else begin
        r_state <= ST_RUN;
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign Forward1Sel = r_fwd1;
  assign Forward2Sel = r_fwd2;
  assign stall       = w_stall;
  assign stall_count = r_stall_cnt;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit with hand-computed expectations.
module tb_forwarding_hazard_unit;

  logic        clk;
  logic        rst;
  logic [2:0]  id_src1;
  logic [2:0]  id_src2;
  logic        id_src1_used;
  logic        id_src2_used;
  logic [2:0]  id_rd;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        id_valid;
  logic        flush;
  logic [1:0]  Forward1Sel;
  logic [1:0]  Forward2Sel;
  logic        stall;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  forwarding_hazard_unit #(.REG_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_src1_used (id_src1_used),
    .id_src2_used (id_src2_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_valid     (id_valid),
    .flush        (flush),
    .Forward1Sel  (Forward1Sel),
    .Forward2Sel  (Forward2Sel),
    .stall        (stall),
    .stall_count  (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [2:0] s1, input logic u1,
                        input logic [2:0] s2, input logic u2, input logic [2:0] rd,
                        input logic rw, input logic mr);
    id_valid     = v;
    id_src1      = s1;
    id_src1_used = u1;
    id_src2      = s2;
    id_src2_used = u2;
    id_rd        = rd;
    id_reg_write = rw;
    id_mem_read  = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b0;
    flush = 1'b0;
    set_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    repeat (2) tick();
    chk("rst_f1", 16'(Forward1Sel), 16'd0);
    chk("rst_f2", 16'(Forward2Sel), 16'd0);
    chk("rst_stall", 16'(stall), 16'd0);
    chk("rst_cnt", stall_count, 16'd0);
    rst = 1'b1;

    // ADD r1 ; ADD r2,r1,r3 -> EX forward on src1
    set_id(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 1'b0);
    tick();
    chk("add1_f1", 16'(Forward1Sel), 16'd0);
    set_id(1'b1, 3'd1, 1'b1, 3'd3, 1'b1, 3'd2, 1'b1, 1'b0);
    #1 chk("b2b_stall", 16'(stall), 16'd0);
    tick();
    chk("b2b_f1", 16'(Forward1Sel), 16'd1);
    chk("b2b_f2", 16'(Forward2Sel), 16'd0);

    // ADD r1 ; NOP ; SUB r4,r5,r1 -> MEM forward on src2
    set_id(1'b1, 3'd6, 1'b1, 3'd7, 1'b1, 3'd1, 1'b1, 1'b0);
    tick();
    chk("gap_add_f1", 16'(Forward1Sel), 16'd0);
    set_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 3'd5, 1'b1, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0);
    tick();
    chk("gap_f1", 16'(Forward1Sel), 16'd0);
    chk("gap_f2", 16'(Forward2Sel), 16'd2);

    // ADD r1 ; ADD r1 ; OR r6,r1 -> EX beats MEM; unused src2 ignored; r0 ordinary
    set_id(1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 3'd1, 1'b1, 1'b0);
    tick();
    chk("r0_f1", 16'(Forward1Sel), 16'd0);
    set_id(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 3'd1, 1'b1, 3'd1, 1'b0, 3'd6, 1'b1, 1'b0);
    tick();
    chk("prio_f1", 16'(Forward1Sel), 16'd1);
    chk("unused_f2", 16'(Forward2Sel), 16'd0);

    // LDD r1 ; ADD r2,r1,r1 -> one stall, bubble, then MEM forward both
    chk("pre_ld_cnt", stall_count, 16'd0);
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 1'b0);
    #1 chk("lu_stall", 16'(stall), 16'd1);
    tick();
    chk("lu_bub_f1", 16'(Forward1Sel), 16'd0);
    chk("lu_bub_f2", 16'(Forward2Sel), 16'd0);
    chk("lu_cnt", stall_count, 16'd1);
    chk("lu_stall_once", 16'(stall), 16'd0);
    tick();
    chk("lu_f1", 16'(Forward1Sel), 16'd2);
    chk("lu_f2", 16'(Forward2Sel), 16'd2);
    chk("lu_cnt_hold", stall_count, 16'd1);

    // Bubbles never forward or stall
    set_id(1'b0, 3'd2, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    tick();
    chk("bub_f1", 16'(Forward1Sel), 16'd0);
    set_id(1'b1, 3'd4, 1'b0, 3'd5, 1'b0, 3'd3, 1'b1, 1'b1);
    tick();
    set_id(1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    #1 chk("bub_nostall", 16'(stall), 16'd0);
    tick();
    chk("bub_ld_f1", 16'(Forward1Sel), 16'd0);

    // Load-use with flush in the same cycle
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 3'd7, 1'b1, 1'b0);
    flush = 1'b1;
    #1 chk("fl_stall_now", 16'(stall), 16'd0);
    tick();
    chk("fl_f1", 16'(Forward1Sel), 16'd0);
    chk("fl_f2", 16'(Forward2Sel), 16'd0);
    chk("fl_cnt", stall_count, 16'd1);
    flush = 1'b0;
    #1 chk("fl_stall_next", 16'(stall), 16'd0);
    tick();
    chk("fl_after_f1", 16'(Forward1Sel), 16'd2);

    // Reset asserted mid-stall
    set_id(1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 3'd1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd3, 1'b1, 1'b1);
    tick();
    chk("rs_pre_f1", 16'(Forward1Sel), 16'd1);
    set_id(1'b1, 3'd3, 1'b1, 3'd0, 1'b1, 3'd2, 1'b1, 1'b0);
    #1 chk("rs_stall", 16'(stall), 16'd1);
    chk("rs_pre_cnt", stall_count, 16'd1);
    rst = 1'b0;
    #1;
    chk("rs_stall_clr", 16'(stall), 16'd0);
    chk("rs_f1", 16'(Forward1Sel), 16'd0);
    chk("rs_f2", 16'(Forward2Sel), 16'd0);
    chk("rs_cnt", stall_count, 16'd0);
    tick();
    rst = 1'b1;
    #1 chk("rs_rel_stall", 16'(stall), 16'd0);
    tick();
    chk("rs_rel_f1", 16'(Forward1Sel), 16'd0);
    chk("rs_rel_f2", 16'(Forward2Sel), 16'd0);
    chk("rs_rel_cnt", stall_count, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
